mem_beat_timer: RTL and testbench

Parametrised, fully synchronous successor to the memory-cycle timing generator. It sequences a fixed number of clocked phases per memory cycle, advances a one-hot beat potential at the end of each cycle unless the instruction is extended, and stretches a cycle on a memory wait. It sits between the CPU control unit, which requests cycles and extensions, and the memory/result-latch strobes.

---
 rtl/mbt_pkg.sv | 28 ++
 rtl/mem_beat_timer_if.sv | 33 +++
 rtl/mbt_onehot_dec.sv | 22 ++
 rtl/mem_beat_timer.sv | 120 ++++++++++++
 tb/tb_mem_beat_timer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbt_pkg.sv
// Shared types and constants for the memory beat timer: FSM states,
// default phase slots and a one-hot helper.
package mbt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STRETCH = 2'd2
  } state_t;

  localparam int unsigned DEF_PHASES  = 5;
  localparam int unsigned DEF_BEATS   = 2;
  localparam int unsigned DEF_RD_PH   = 0;
  localparam int unsigned DEF_WR_PH   = 1;
  localparam int unsigned DEF_WAIT_PH = 2;
  localparam int unsigned DEF_EXT_PH  = 3;

  localparam int unsigned ONEHOT_MAX  = 64;

  // One-hot of idx within an n-wide field; zero when idx is out of range.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (idx < n && idx < ONEHOT_MAX) v = ONEHOT_MAX'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/mem_beat_timer_if.sv
// Control/strobe bundle between the CPU control unit and the beat timer.
interface mem_beat_timer_if
  import mbt_pkg::*;
#(
  parameter int unsigned PHASES = DEF_PHASES,
  parameter int unsigned BEATS  = DEF_BEATS
);
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic              i_start;
  logic              i_halt;
  logic              i_wait;
  logic              i_extend;
  logic [PHASES-1:0] o_phase;
  logic [BEATS-1:0]  o_beat;
  logic [BW-1:0]     o_beat_idx;
  logic              o_busy;
  logic              o_ext;
  logic              o_rd;
  logic              o_wr;
  logic              o_cycle_end;

  modport master (
    output i_start, i_halt, i_wait, i_extend,
    input  o_phase, o_beat, o_beat_idx, o_busy, o_ext, o_rd, o_wr, o_cycle_end
  );

  modport slave (
    input  i_start, i_halt, i_wait, i_extend,
    output o_phase, o_beat, o_beat_idx, o_busy, o_ext, o_rd, o_wr, o_cycle_end
  );

endinterface

// File: rtl/mbt_onehot_dec.sv
// Binary-to-one-hot decoder with enable, shared by the phase and beat outputs.
module mbt_onehot_dec
  import mbt_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  y
);

  if (N > ONEHOT_MAX) begin : g_chk_n
    $error("mbt_onehot_dec: N exceeds ONEHOT_MAX");
  end

  always_comb begin
    y = '0;
    if (en) y = N'(onehot(32'(idx), N));
  end

endmodule

// File: rtl/mem_beat_timer.sv
// Memory-cycle timing generator: walks PHASES slots per cycle, stretches on
// a memory wait and advances a one-hot beat at each unextended cycle end.
module mem_beat_timer
  import mbt_pkg::*;
#(
  parameter int unsigned PHASES  = DEF_PHASES,
  parameter int unsigned BEATS   = DEF_BEATS,
  parameter int unsigned RD_PH   = DEF_RD_PH,
  parameter int unsigned WR_PH   = DEF_WR_PH,
  parameter int unsigned WAIT_PH = DEF_WAIT_PH,
  parameter int unsigned EXT_PH  = DEF_EXT_PH
) (
  input  logic             clk,
  input  logic             rst,
  mem_beat_timer_if.slave  bus
);

  localparam int unsigned PW   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAST = PHASES - 1;

  if (PHASES < 3) begin : g_chk_phases
    $error("mem_beat_timer: PHASES must be >= 3");
  end
  if (BEATS < 2) begin : g_chk_beats
    $error("mem_beat_timer: BEATS must be >= 2");
  end
  if (RD_PH >= PHASES || WR_PH >= PHASES || WAIT_PH >= PHASES || EXT_PH >= PHASES) begin : g_chk_ph
    $error("mem_beat_timer: every *_PH must be < PHASES");
  end

  state_t        state, state_n;
  logic [PW-1:0] ph, ph_n;
  logic [BW-1:0] bt, bt_n;
  logic          ext, ext_n;
  logic          wait_done, wait_done_n;
  logic          stall_c, end_c, busy_c;

  // wait_done marks the slot right after a stretch so a wait on the last
  // phase is honoured only once before the cycle closes.
  assign stall_c = (state == RUN) && (ph == PW'(WAIT_PH)) && bus.i_wait && !wait_done;
  assign end_c   = (state == RUN) && (ph == PW'(LAST)) && !stall_c;
  assign busy_c  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ph        <= '0;
      bt        <= '0;
      ext       <= 1'b0;
      wait_done <= 1'b0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      bt        <= bt_n;
      ext       <= ext_n;
      wait_done <= wait_done_n;
    end
  end

  // Next-state: phase walk, stretch hold, cycle-end beat advance and restart.
  always_comb begin
    state_n     = state;
    ph_n        = ph;
    bt_n        = bt;
    ext_n       = ext;
    wait_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          state_n = RUN;
          ph_n    = '0;
        end
      end
      RUN: begin
        if (ph == PW'(EXT_PH)) ext_n = bus.i_extend;
        if (stall_c) begin
          state_n = STRETCH;
        end else if (end_c) begin
          if (!ext) bt_n = (bt == BW'(BEATS - 1)) ? '0 : bt + BW'(1);
          ph_n = '0;
          if (!(bus.i_start && !bus.i_halt)) state_n = IDLE;
        end else begin
          ph_n = ph + PW'(1);
        end
      end
      STRETCH: begin
        if (!bus.i_wait) begin
          state_n     = RUN;
          wait_done_n = 1'b1;
          if (WAIT_PH != LAST) ph_n = ph + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode straight from the state registers.
  always_comb begin
    bus.o_busy      = busy_c;
    bus.o_rd        = (state == RUN) && (ph == PW'(RD_PH)) && (bt == '0);
    bus.o_wr        = (state == RUN) && (ph == PW'(WR_PH)) && (bt == BW'(BEATS - 1));
    bus.o_cycle_end = end_c;
    bus.o_ext       = ext;
    bus.o_beat_idx  = bt;
  end

  mbt_onehot_dec #(.N(PHASES), .IW(PW)) u_phase_dec (
    .idx (ph),
    .en  (busy_c),
    .y   (bus.o_phase)
  );

  mbt_onehot_dec #(.N(BEATS), .IW(BW)) u_beat_dec (
    .idx (bt),
    .en  (1'b1),
    .y   (bus.o_beat)
  );

endmodule

// File: tb/tb_mem_beat_timer.sv
// Scoreboard bench for mem_beat_timer: random cycles with waits, extends and
// halts against a per-cycle reference model, plus an 8-phase/4-beat run.
module tb_mem_beat_timer;

  localparam int P   = 5;
  localparam int B   = 2;
  localparam int RDP = 0;
  localparam int WRP = 1;
  localparam int WTP = 2;
  localparam int EXP = 3;

  typedef struct {
    int w;
    bit ext;
    bit st;
    bit hl;
  } cyc_t;

  typedef struct {
    int bt;
    int len;
    int w;
    bit ext;
    int rd;
    int wr;
    bit b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_bt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_beat_timer_if #(.PHASES(P), .BEATS(B)) bus_a ();
  mem_beat_timer_if #(.PHASES(8), .BEATS(4)) bus_b ();

  mem_beat_timer #(
    .PHASES(P), .BEATS(B), .RD_PH(RDP), .WR_PH(WRP), .WAIT_PH(WTP), .EXT_PH(EXP)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_beat_timer #(.PHASES(8), .BEATS(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic fail_note(input string name, input string what);
    n_chk++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Phase visible in slot s of a cycle whose wait lasts w clocks.
  function automatic int exp_phase(input int s, input int w);
    if (s <= WTP) return s;
    else if (s <= WTP + w) return WTP;
    else return s - w;
  endfunction

  // Reference model: the beat seen during a cycle, and its successor.
  task automatic push(input cyc_t c);
    exp_t e;
    e.bt  = m_bt;
    e.len = P + c.w;
    e.w   = c.w;
    e.ext = c.ext;
    e.rd  = (m_bt == 0) ? 1 : 0;
    e.wr  = (m_bt == B - 1) ? 1 : 0;
    e.b2b = c.st && !c.hl;
    sb.push_back(e);
    if (!c.ext) m_bt = (m_bt + 1) % B;
  endtask

  task automatic body(input cyc_t c);
    int p;
    for (int s = 0; s < P + c.w; s++) begin
      p = exp_phase(s, c.w);
      bus_a.i_wait   = (p == WTP) ? (s < WTP + c.w) : 1'($urandom_range(0, 1));
      bus_a.i_extend = (p == EXP) ? c.ext : 1'($urandom_range(0, 1));
      if (s == P + c.w - 1) begin
        bus_a.i_start = c.st;
        bus_a.i_halt  = c.hl;
      end else begin
        bus_a.i_start = 1'($urandom_range(0, 1));
        bus_a.i_halt  = 1'($urandom_range(0, 1));
      end
      if (s < P + c.w - 1) @(negedge clk);
    end
  endtask

  task automatic run_seq(input cyc_t cs_in[$]);
    cyc_t cs[$];
    bit   in_run;
    cs = cs_in;
    if (cs[cs.size()-1].st) cs[cs.size()-1].hl = 1'b1;
    in_run = 1'b0;
    for (int i = 0; i < cs.size(); i++) begin
      if (!in_run) begin
        bus_a.i_start  = 1'b0;
        bus_a.i_halt   = 1'($urandom_range(0, 1));
        bus_a.i_wait   = 1'($urandom_range(0, 1));
        bus_a.i_extend = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus_a.i_start = 1'b1;
        push(cs[i]);
        @(negedge clk);
      end
      body(cs[i]);
      in_run = cs[i].st && !cs[i].hl;
      if (in_run) push(cs[i+1]);
      @(negedge clk);
    end
    bus_a.i_start = 1'b0;
    bus_a.i_halt  = 1'b0;
    bus_a.i_wait  = 1'b0;
  endtask

  function automatic cyc_t mk(input int w, input bit ext, input bit st, input bit hl);
    cyc_t c;
    c.w = w; c.ext = ext; c.st = st; c.hl = hl;
    return c;
  endfunction

  // Monitor: follows each cycle the DUT presents and checks it against the
  // expectation at the head of the scoreboard.
  initial begin
    exp_t cur;
    int   slot, rdc, wrc;
    bit   in_cyc, exp_idle;
    in_cyc = 1'b0;
    exp_idle = 1'b0;
    slot = 0; rdc = 0; wrc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_cyc = 1'b0;
        exp_idle = 1'b0;
        continue;
      end
      chk("beat_onehot", bus_a.o_beat, 1 << bus_a.o_beat_idx);
      if (exp_idle) begin
        chk("idle_after_end", bus_a.o_busy, 0);
        exp_idle = 1'b0;
      end
      if (!bus_a.o_busy) begin
        if (in_cyc) begin
          fail_note("busy_drop", "DUT idle before cycle end");
          in_cyc = 1'b0;
        end
        chk("idle_phase", bus_a.o_phase, 0);
        chk("idle_strobes", {bus_a.o_rd, bus_a.o_wr, bus_a.o_cycle_end}, 0);
        continue;
      end
      if (!in_cyc) begin
        if (sb.size() == 0) begin
          fail_note("sb_empty", "busy with no expected cycle");
          continue;
        end
        cur = sb[0];
        slot = 0; rdc = 0; wrc = 0;
        in_cyc = 1'b1;
        chk("cyc_beat", bus_a.o_beat_idx, cur.bt);
      end
      chk("phase", bus_a.o_phase, 1 << exp_phase(slot, cur.w));
      rdc += int'(bus_a.o_rd);
      wrc += int'(bus_a.o_wr);
      chk("cycle_end", bus_a.o_cycle_end, (slot == cur.len - 1) ? 1 : 0);
      if (bus_a.o_cycle_end || slot == cur.len - 1) begin
        chk("rd_count", rdc, cur.rd);
        chk("wr_count", wrc, cur.wr);
        chk("ext", bus_a.o_ext, cur.ext);
        chk("beat_hold", bus_a.o_beat_idx, cur.bt);
        void'(sb.pop_front());
        in_cyc = 1'b0;
        exp_idle = !cur.b2b;
      end else begin
        slot++;
      end
    end
  end

  initial begin
    cyc_t q[$];
    int   n;
    bus_a.i_start = 1'b0; bus_a.i_halt = 1'b0; bus_a.i_wait = 1'b0; bus_a.i_extend = 1'b0;
    bus_b.i_start = 1'b0; bus_b.i_halt = 1'b0; bus_b.i_wait = 1'b0; bus_b.i_extend = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phase", bus_a.o_phase, 0);
    chk("rst_beat", bus_a.o_beat, 1);
    chk("rst_beat_idx", bus_a.o_beat_idx, 0);
    chk("rst_outs", {bus_a.o_busy, bus_a.o_ext, bus_a.o_rd, bus_a.o_wr, bus_a.o_cycle_end}, 0);
    rst = 1'b0;
    @(negedge clk);

    // single cycle, back-to-back, extend, stretch, halt
    q = {mk(0, 0, 0, 0)};                                               run_seq(q);
    q = {mk(0, 0, 1, 0), mk(0, 0, 1, 0), mk(0, 0, 1, 0), mk(0, 0, 0, 0)}; run_seq(q);
    q = {mk(0, 1, 1, 0), mk(0, 0, 1, 0), mk(0, 0, 1, 0), mk(0, 0, 0, 0)}; run_seq(q);
    q = {mk(3, 0, 0, 0)};                                               run_seq(q);
    q = {mk(0, 0, 1, 1), mk(1, 0, 1, 1), mk(2, 1, 0, 0)};               run_seq(q);

    q.delete();
    for (int i = 0; i < 40; i++)
      q.push_back(mk($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0));
    run_seq(q);

    // reset mid-cycle at phase 3, with o_ext set from the previous cycle
    q = {mk(0, 1, 0, 0)}; run_seq(q);
    bus_a.i_start = 1'b1;
    push(mk(0, 0, 0, 0));
    repeat (4) @(negedge clk);
    bus_a.i_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_phase", bus_a.o_phase, 0);
    chk("mid_rst_beat", bus_a.o_beat, 1);
    chk("mid_rst_beat_idx", bus_a.o_beat_idx, 0);
    chk("mid_rst_outs", {bus_a.o_busy, bus_a.o_ext, bus_a.o_rd, bus_a.o_wr, bus_a.o_cycle_end}, 0);
    sb.delete();
    m_bt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    q.delete();
    for (int i = 0; i < 10; i++)
      q.push_back(mk($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) != 0, 1'b0));
    run_seq(q);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // 8 phases, 4 beats, 5 back-to-back cycles
    bus_b.i_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("b_phase0", bus_b.o_phase, 1);
      chk("b_beat_idx", bus_b.o_beat_idx, k % 4);
      n = 1;
      while (!bus_b.o_cycle_end && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b_cycle_len", n, 8);
      if (k == 4) bus_b.i_start = 1'b0;
      @(negedge clk);
    end
    chk("b_idle", bus_b.o_busy, 0);
    chk("b_final_beat", bus_b.o_beat_idx, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
